// File: rtl/genclk_pkg.sv
// Shared defaults, capture entry layout and FIFO sizing helper for the
// programmable clock generator and bus access tracer.
package genclk_pkg;

  localparam int DIV_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int ADR_WIDTH_DEF = 7;
  localparam int DEPTH_DEF     = 8;

  typedef struct packed {
    logic [CNT_WIDTH_DEF-1:0] count;
    logic [ADR_WIDTH_DEF-1:0] adr;
    logic                     write;
  } capture_entry_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/genclk_fifo.sv
// First-word-fall-through FIFO with a registered head: entries land in the
// array first and are moved into the output register on the following edge.
module genclk_fifo
  import genclk_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         full,
  input  logic                         pop_req,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [occ_width(DEPTH)-1:0]  fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [FW-1:0]    mem_cnt;
  logic             pop;
  logic             load;

  // Occupancy spans the array plus the head register; the caller only
  // pushes while not full or while the head is popped in the same cycle.
  assign pop  = out_valid && pop_req;
  assign load = (mem_cnt != '0) && (!out_valid || pop);
  assign fill = mem_cnt + FW'(out_valid);
  assign full = (fill == FW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) begin
        out_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PW'(1);
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + FW'(push) - FW'(load);
    end
  end

endmodule

// File: rtl/genclk_tracer.sv
// Programmable-ratio target clock with glitch-free start/stop, a rising-edge
// counter, and timestamped capture of matching cartridge-bus accesses.
module genclk_tracer
  import genclk_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int ADR_WIDTH = ADR_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic [DIV_WIDTH-1:0]        half_period,
  input  logic                        start,
  input  logic                        stop,
  output logic                        clkout,
  output logic                        clkout_rise,
  output logic [CNT_WIDTH-1:0]        count,
  input  logic [ADR_WIDTH-1:0]        adr,
  input  logic                        n_read,
  input  logic                        n_write,
  input  logic                        n_cs,
  input  logic [ADR_WIDTH-1:0]        match_adr,
  input  logic [ADR_WIDTH-1:0]        adr_mask,
  input  logic                        rd_en,
  input  logic                        wr_en,
  input  logic                        one_shot,
  input  logic                        arm,
  output logic                        done,
  output logic                        overflow,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic [ADR_WIDTH-1:0]        out_adr,
  output logic                        out_write,
  output logic [occ_width(DEPTH)-1:0] fill
);

  typedef struct packed {
    logic [CNT_WIDTH-1:0] count;
    logic [ADR_WIDTH-1:0] adr;
    logic                 write;
  } entry_t;

  logic                 running;
  logic                 stop_pending;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] hp_reg;
  logic                 eff_stop;
  logic                 terminal;
  logic                 halt_now;

  // A start cancels a pending stop, but a stop in the same cycle still wins.
  always_comb begin
    eff_stop = stop || (stop_pending && !start);
    terminal = running && (div_cnt == hp_reg);
    halt_now = running && eff_stop && !clkout;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      running      <= 1'b0;
      stop_pending <= 1'b0;
      div_cnt      <= '0;
      hp_reg       <= '0;
      clkout       <= 1'b0;
      clkout_rise  <= 1'b0;
      count        <= '0;
    end else begin
      clkout_rise <= 1'b0;
      if (clkout_rise) count <= count + CNT_WIDTH'(1);
      if (!running) begin
        stop_pending <= 1'b0;
        if (start && !stop) begin
          running <= 1'b1;
          div_cnt <= '0;
          hp_reg  <= half_period;
        end
      end else if (halt_now) begin
        running      <= 1'b0;
        stop_pending <= 1'b0;
        div_cnt      <= '0;
      end else if (terminal) begin
        // A stop reaching a terminal count here always lands on a falling toggle.
        clkout       <= !clkout;
        clkout_rise  <= !clkout;
        div_cnt      <= '0;
        hp_reg       <= half_period;
        running      <= !eff_stop;
        stop_pending <= 1'b0;
      end else begin
        div_cnt      <= div_cnt + DIV_WIDTH'(1);
        stop_pending <= eff_stop;
      end
    end
  end

  logic   bus_hit;
  logic   match_q;
  logic   event_hit;
  logic   done_eff;
  logic   ovf_eff;
  logic   want_push;
  logic   can_push;
  logic   push;
  logic   fifo_full;
  entry_t entry;
  entry_t head;

  // arm clears the flags before a coincident event is evaluated.
  always_comb begin
    bus_hit   = !n_cs && ((rd_en && !n_read) || (wr_en && !n_write)) &&
                (((adr ^ match_adr) & adr_mask) == '0);
    event_hit = bus_hit && !match_q;
    done_eff  = done && !arm;
    ovf_eff   = overflow && !arm;
    want_push = event_hit && !(one_shot && done_eff);
    can_push  = !fifo_full || (out_valid && out_ready);
    push      = want_push && can_push;
    entry       = '0;
    entry.count = count;
    entry.adr   = adr;
    entry.write = !n_write;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      match_q  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      match_q  <= bus_hit;
      done     <= done_eff || (push && one_shot);
      overflow <= ovf_eff || (want_push && !can_push);
    end
  end

  genclk_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (push),
    .push_data (entry),
    .full      (fifo_full),
    .pop_req   (out_ready),
    .out_valid (out_valid),
    .out_data  (head),
    .fill      (fill)
  );

  assign out_count = head.count;
  assign out_adr   = head.adr;
  assign out_write = head.write;

endmodule

// File: tb/tb_genclk_tracer.sv
// Directed test-plan scenarios plus randomized traffic, checked every cycle
// against a queue-based behavioural model of the generator and tracer.
module tb_genclk_tracer;
  import genclk_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [3:0]  half_period;
  logic        start, stop;
  logic        clkout, clkout_rise;
  logic [31:0] count;
  logic [6:0]  adr, match_adr, adr_mask;
  logic        n_read, n_write, n_cs;
  logic        rd_en, wr_en, one_shot, arm;
  logic        done, overflow, out_valid, out_ready;
  logic [31:0] out_count;
  logic [6:0]  out_adr;
  logic        out_write;
  logic [3:0]  fill;

  always #5 clk = ~clk;

  genclk_tracer #(.DIV_WIDTH(4), .CNT_WIDTH(32), .ADR_WIDTH(7), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_reset(n_reset), .half_period(half_period), .start(start), .stop(stop),
    .clkout(clkout), .clkout_rise(clkout_rise), .count(count),
    .adr(adr), .n_read(n_read), .n_write(n_write), .n_cs(n_cs),
    .match_adr(match_adr), .adr_mask(adr_mask), .rd_en(rd_en), .wr_en(wr_en),
    .one_shot(one_shot), .arm(arm), .done(done), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_adr(out_adr), .out_write(out_write), .fill(fill)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    capture_entry_t e;
    int             pe;
  } qitem_t;

  bit          m_run, m_clk, m_pend, m_rise, m_done, m_ovf, m_prev_match;
  int          m_left;
  int          edges;
  logic [31:0] m_count;
  qitem_t      m_q[$];

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_clk = 0; m_pend = 0; m_rise = 0; m_done = 0; m_ovf = 0;
    m_prev_match = 0; m_left = 0; edges = 0; m_count = '0;
    m_q.delete();
  endtask

  // An entry becomes visible one edge after the edge that stored it.
  function automatic bit head_visible();
    return (m_q.size() > 0) && (m_q[0].pe <= edges - 1);
  endfunction

  task automatic model_edge();
    bit hit, ev, pop, was_full, d, o, es, nr;
    qitem_t it;
    hit = !n_cs && ((rd_en && !n_read) || (wr_en && !n_write)) &&
          (((adr ^ match_adr) & adr_mask) == 7'h00);
    ev = hit && !m_prev_match;
    pop = head_visible() && out_ready;
    was_full = (m_q.size() == DEPTH);
    d = m_done && !arm;
    o = m_ovf && !arm;
    if (pop) void'(m_q.pop_front());
    if (ev && !(one_shot && d)) begin
      if (!was_full || pop) begin
        it.e.count = m_count;
        it.e.adr   = adr;
        it.e.write = !n_write;
        it.pe      = edges + 1;
        m_q.push_back(it);
        if (one_shot) d = 1;
      end else begin
        o = 1;
      end
    end
    m_done = d;
    m_ovf = o;
    m_prev_match = hit;

    es = stop || (m_pend && !start);
    nr = 0;
    if (!m_run) begin
      if (start && !stop) begin
        m_run = 1;
        m_left = int'(half_period) + 1;
      end
      m_pend = 0;
    end else if (es && !m_clk) begin
      m_run = 0;
      m_pend = 0;
    end else begin
      m_pend = es;
      m_left--;
      if (m_left == 0) begin
        nr = !m_clk;
        m_clk = !m_clk;
        m_left = int'(half_period) + 1;
        if (es) begin
          m_run = 0;
          m_pend = 0;
        end
      end
    end
    if (m_rise) m_count = m_count + 32'd1;
    m_rise = nr;
    edges++;
  endtask

  task automatic compare_all();
    check_output("clkout", clkout, m_clk);
    check_output("clkout_rise", clkout_rise, m_rise);
    check_output("count", count, m_count);
    check_output("done", done, m_done);
    check_output("overflow", overflow, m_ovf);
    check_output("fill", fill, m_q.size());
    check_output("out_valid", out_valid, head_visible());
    if (head_visible()) begin
      check_output("out_count", out_count, m_q[0].e.count);
      check_output("out_adr", out_adr, m_q[0].e.adr);
      check_output("out_write", out_write, m_q[0].e.write);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_rise(output int n);
    for (n = 1; n <= 200; n++) begin
      tick();
      if (clkout_rise) break;
    end
    check_output("rise_seen", clkout_rise, 1'b1);
  endtask

  task automatic access(input logic [6:0] a, input bit wr, input int len);
    adr = a;
    n_cs = 0;
    if (wr) n_write = 0; else n_read = 0;
    repeat (len) tick();
    n_cs = 1; n_read = 1; n_write = 1;
    tick();
  endtask

  task automatic apply_stimulus();
    logic [3:0] lo;
    lo = 4'($urandom);
    start = ($urandom_range(0, 39) == 0);
    stop  = ($urandom_range(0, 59) == 0);
    if ($urandom_range(0, 19) == 0) half_period = 4'($urandom);
    n_cs    = ($urandom_range(0, 2) == 0);
    n_read  = 1'($urandom);
    n_write = 1'($urandom);
    adr = ($urandom_range(0, 1) == 1) ? {match_adr[6:4], lo} : 7'($urandom);
    arm = ($urandom_range(0, 29) == 0);
    out_ready = ($urandom_range(0, 2) != 0);
    if ($urandom_range(0, 199) == 0) one_shot = !one_shot;
    if ($urandom_range(0, 149) == 0) rd_en = !rd_en;
    if ($urandom_range(0, 149) == 0) wr_en = !wr_en;
  endtask

  initial begin
    int n, rises;
    logic [31:0] saved;
    n_reset = 1; half_period = 0; start = 0; stop = 0;
    adr = 0; n_read = 1; n_write = 1; n_cs = 1;
    match_adr = 0; adr_mask = 7'h7f; rd_en = 0; wr_en = 0;
    one_shot = 0; arm = 0; out_ready = 0;
    #1 n_reset = 0;
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1;
    model_reset();
    compare_all();
    check_output("rst_clkout", clkout, 1'b0);
    check_output("rst_count", count, 32'd0);
    check_output("rst_fill", fill, 4'd0);

    $display("[TB] divider and timestamp");
    half_period = 7;
    start = 1; tick(); start = 0;
    wait_rise(n);
    check_output("first_rise_delay", n, 8);
    wait_rise(n);
    check_output("period", n, 16);
    rises = 2;
    while (rises < 100) begin
      wait_rise(n);
      rises++;
    end
    tick();
    check_output("count_100", count, 32'd100);
    one_shot = 1; match_adr = 7'h00; adr_mask = 7'h7f; rd_en = 1; wr_en = 0;
    access(7'h00, 0, 1);
    tick();
    check_output("ts_valid", out_valid, 1'b1);
    check_output("ts_count", out_count, 32'd100);
    check_output("ts_adr", out_adr, 7'h00);
    check_output("ts_write", out_write, 1'b0);
    check_output("ts_done", done, 1'b1);
    access(7'h00, 0, 1);
    tick();
    check_output("one_shot_fill", fill, 4'd1);
    out_ready = 1; tick(); out_ready = 0;

    $display("[TB] stop and restart");
    wait_rise(n);
    repeat (3) tick();
    stop = 1; tick(); stop = 0;
    saved = count;
    repeat (40) tick();
    check_output("stop_clkout", clkout, 1'b0);
    check_output("stop_count", count, saved);
    start = 1; tick(); start = 0;
    wait_rise(n);
    check_output("restart_delay", n, 8);

    $display("[TB] masked continuous");
    one_shot = 0; adr_mask = 7'h70; match_adr = 7'h10; rd_en = 1; wr_en = 1;
    access(7'h13, 1, 1);
    access(7'h1f, 0, 1);
    access(7'h20, 0, 1);
    access(7'h13, 1, 5);
    tick();
    check_output("mask_fill", fill, 4'd3);
    check_output("mask_head_adr", out_adr, 7'h13);
    check_output("mask_head_wr", out_write, 1'b1);
    out_ready = 1; tick(); out_ready = 0;
    check_output("mask_second_adr", out_adr, 7'h1f);
    check_output("mask_second_wr", out_write, 1'b0);
    out_ready = 1; repeat (3) tick(); out_ready = 0;
    tick();
    check_output("mask_drained", fill, 4'd0);

    $display("[TB] overflow");
    repeat (9) access(7'h10, 1, 1);
    check_output("ovf_fill", fill, 4'd8);
    check_output("ovf_flag", overflow, 1'b1);
    arm = 1; tick(); arm = 0;
    check_output("arm_ovf", overflow, 1'b0);
    check_output("arm_fill", fill, 4'd8);
    adr = 7'h10; n_cs = 0; n_write = 0; out_ready = 1;
    tick();
    out_ready = 0; n_cs = 1; n_write = 1;
    tick();
    check_output("full_pop_fill", fill, 4'd8);
    check_output("full_pop_ovf", overflow, 1'b0);
    out_ready = 1; repeat (12) tick(); out_ready = 0;

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus();
      tick();
    end

    $display("[TB] reset mid-run");
    start = 0; stop = 0; arm = 0; n_cs = 1; n_read = 1; n_write = 1;
    one_shot = 0; rd_en = 1; wr_en = 1; half_period = 3;
    out_ready = 1; repeat (12) tick(); out_ready = 0;
    start = 1; tick(); start = 0;
    repeat (3) access(7'h15, 1, 1);
    repeat (2) tick();
    check_output("pre_reset_fill", fill, 4'd3);
    #2 n_reset = 0;
    #1;
    check_output("async_clkout", clkout, 1'b0);
    check_output("async_count", count, 32'd0);
    check_output("async_fill", fill, 4'd0);
    check_output("async_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1;
    model_reset();
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
